// File: rtl/ctrl_blk_pkg.sv
// Shared definitions for the 2-mode control block: lane encoding and word geometry.
// The read-side strobe counter reuses lane_t for its own mod-4 states.
package ctrl_blk_pkg;

   localparam int LANES  = 4;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      BYTE0 = 2'd0,
      BYTE1 = 2'd1,
      BYTE2 = 2'd2,
      BYTE3 = 2'd3
   } lane_t;

   // Explicit wrap so every state has a defined successor.
   function automatic lane_t next_lane(input lane_t l);
      lane_t n;
      case (l)
         BYTE0:   n = BYTE1;
         BYTE1:   n = BYTE2;
         BYTE2:   n = BYTE3;
         BYTE3:   n = BYTE0;
         default: n = BYTE0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous active-high reset.
module sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/wr_cnt_sm.sv
// Write-side byte-lane packer: four bytes per word, big-endian, into a one-entry
// holding register that feeds the word FIFO; words lost to back-pressure are counted.
module wr_cnt_sm #(
   parameter int BYTE_W = ctrl_blk_pkg::BYTE_W,
   parameter int LANES  = ctrl_blk_pkg::LANES,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    data_ena,
   input  logic [BYTE_W-1:0]       data_in,
   input  logic                    fifo_full,
   output logic                    fifo_wr,
   output logic [LANES*BYTE_W-1:0] fifo_wdata,
   output logic [1:0]              wr_lane,
   output logic                    overflow,
   output logic [CNT_W-1:0]        words_wr,
   output logic [CNT_W-1:0]        words_drop
);

   import ctrl_blk_pkg::*;

   localparam int WORD_W = LANES * BYTE_W;

   lane_t             lane_q, lane_d;
   logic [WORD_W-1:0] asm_q, asm_d;
   logic [WORD_W-1:0] asm_merged;
   logic [WORD_W-1:0] hold_data_q, hold_data_d;
   logic              hold_valid_q, hold_valid_d;
   logic              overflow_q, overflow_d;
   logic              word_done;
   logic              drop;

   // FIFO handshake: a word transfers on a rising edge where fifo_wr=1. fifo_wr is
   // hold_valid_q & ~fifo_full, so it is never raised while the FIFO reports full
   // and it never depends on this cycle's data_ena.
   assign fifo_wr = hold_valid_q & ~fifo_full;

   assign word_done = data_ena && (lane_q == BYTE3);
   assign drop      = word_done && hold_valid_q && !fifo_wr;

   // Byte for the current lane merged into the assembly register; BYTE0 lands in the MSBs.
   always_comb begin
      asm_merged = asm_q;
      asm_merged[(LANES - 1 - int'(lane_q)) * BYTE_W +: BYTE_W] = data_in;
   end

   always_comb begin
      lane_d       = lane_q;
      asm_d        = asm_q;
      hold_data_d  = hold_data_q;
      hold_valid_d = hold_valid_q;
      overflow_d   = overflow_q;

      if (data_ena) begin
         lane_d = next_lane(lane_q);
         asm_d  = asm_merged;
      end

      // A completing word wins the hold slot whenever the slot is empty or draining.
      if (word_done && !drop) begin
         hold_data_d  = asm_merged;
         hold_valid_d = 1'b1;
      end else if (fifo_wr) begin
         hold_valid_d = 1'b0;
      end

      if (drop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lane_q       <= BYTE0;
         asm_q        <= '0;
         hold_data_q  <= '0;
         hold_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         lane_q       <= lane_d;
         asm_q        <= asm_d;
         hold_data_q  <= hold_data_d;
         hold_valid_q <= hold_valid_d;
         overflow_q   <= overflow_d;
      end
   end

   sat_cnt #(.W(CNT_W)) u_words_wr (
      .clk   (clk),
      .reset (reset),
      .inc   (fifo_wr),
      .q     (words_wr)
   );

   sat_cnt #(.W(CNT_W)) u_words_drop (
      .clk   (clk),
      .reset (reset),
      .inc   (drop),
      .q     (words_drop)
   );

   assign fifo_wdata = hold_data_q;
   assign wr_lane    = lane_q;
   assign overflow   = overflow_q;

endmodule

// File: doc/wr_cnt_sm.md
# wr_cnt_sm

Write-side byte-lane controller for the 2-mode control block. Accepts a byte stream, packs four bytes per 32-bit word with a mod-4 lane state machine, and writes each finished word into the word FIFO. It is the producer end of the FIFO whose consumer side counts `fifo_rd` strobes mod 4. A one-word holding register absorbs FIFO back-pressure. Loss is flagged.

## Interface
- `BYTE_W`, default 8: byte width.
- `LANES`, default 4: bytes per word. Fixed at 4; the state encoding depends on it.
- `CNT_W`, default 16: width of the written and dropped word counters.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: reset is synchronous and active-high.
- `data_ena`, input, 1: `data_in` is valid this cycle. One byte is accepted per cycle with `data_ena` high.
- `data_in`, input, `BYTE_W`: byte data.
- `fifo_full`, input, 1: FIFO cannot accept a write this cycle.
- `fifo_wr`, output, 1: write strobe; writes `fifo_wdata` at this edge.
- `fifo_wdata`, output, `LANES*BYTE_W`: word from the holding register.
- `wr_lane`, output, 2: current lane state encoding (0–3).
- `overflow`, output, 1: sticky flag, set on first dropped word.
- `words_wr`, output, `CNT_W`: count of words written; saturates.
- `words_drop`, output, `CNT_W`: count of words dropped; saturates.

## Operation
- Lane state machine, states `BYTE0`=0, `BYTE1`=1, `BYTE2`=2, `BYTE3`=3:
  - `data_ena`=1: advance BYTE0→1→2→3→0.
  - `data_ena`=0: hold state. There is no X/default next state; every state has a defined next state.
- Byte placement, big-endian:
  - In `BYTEn`, `data_in` loads assembly bits `[(LANES-1-n)*BYTE_W +: BYTE_W]`. BYTE0 fills `[31:24]`.
- Word completion: `data_ena`=1 in `BYTE3`. The completed word is the assembly register with the final byte merged in.
- Holding register (`hold_data`, `hold_valid`):
  - `fifo_wr = hold_valid & ~fifo_full`. Combinational from registered state; no dependence on `data_ena`.
  - When `fifo_wr`=1: `hold_valid` clears and `words_wr` increments, unless a word completes at the same edge (see below).
  - Word completes with `hold_valid`=0, or with `hold_valid`=1 and `fifo_wr`=1: the word loads into hold and `hold_valid`=1. Simultaneous drain and load is legal and loses nothing.
  - Word completes with `hold_valid`=1 and `fifo_wr`=0: the new word is dropped. Hold keeps the old word, `words_drop` increments, and `overflow` sets. Lane assembly continues with no stall upstream.
- Counters saturate at `2**CNT_W-1`. `overflow` clears only on `reset`.
- `fifo_wdata` always shows `hold_data`. It is meaningful only while `fifo_wr`=1.

## Timing
- Reset values (at the first edge with `reset`=1):
  - lane state = `BYTE0`, assembly register = 0.
  - `hold_valid`=0, `hold_data`=0, so `fifo_wr`=0 and `fifo_wdata`=0.
  - `overflow`=0, `words_wr`=0, `words_drop`=0.
- Reset mid-word discards partial bytes and any held word. Neither is counted as dropped.
- Latency: if the FIFO is not full, `fifo_wr` rises in the cycle after the edge that accepts the 4th byte.
  - Sustained throughput: one word per 4 cycles of `data_ena`.
  - Back-to-back completions cannot occur (minimum 4 cycles apart), so a single hold entry suffices whenever `fifo_full` clears within 3 cycles.
- `fifo_full` is sampled in the same cycle as `fifo_wr` is evaluated. The FIFO must treat `fifo_wr` as ignored-when-full; this block never asserts `fifo_wr` while `fifo_full`=1.

## Structure
- Shared package `ctrl_blk_pkg`:
  - `typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2, BYTE3} lane_t`.
  - `LANES` and `BYTE_W` constants.
  - The read side's counter states reuse the same encoding.
- One sub-module, `sat_cnt` (parameter `W`; ports `clk`, `reset`, `inc`, `q`), instantiated twice for `words_wr` and `words_drop`.
- Lane state machine, assembly, and hold logic stay inline.

## Test plan
- Reset, then bytes 0x11,0x22,0x33,0x44 on consecutive cycles with `fifo_full`=0 → `fifo_wr`=1 for one cycle with `fifo_wdata`=0x11223344; `words_wr`=1; `wr_lane` back to 0.
- `data_ena` gapped (byte, 2 idle, byte, …) for 0xA0..0xA3 → lane holds during gaps; single write 0xA0A1A2A3.
- `fifo_full`=1 while word 0x01020304 completes, released 2 cycles later → `fifo_wr` stays 0 while full, then one write of 0x01020304; `overflow`=0.
- `fifo_full` held high across two completed words (0x01020304 then 0x05060708) → second word dropped, `words_drop`=1, `overflow`=1. After release, one write of 0x01020304; `overflow` stays 1.
- Hold valid and `fifo_full` falls on the same edge the next word completes → old word written and new word loaded together; `words_drop`=0; the next cycle writes the new word.
- `reset` asserted after 2 bytes of a word → `wr_lane`=0 and no write. The next 4 bytes form a clean word; counters restart from 0.
